// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle for the two requesters (A and B) of the shared UART transmitter.
// The requester side is the master and the arbiter is the slave.
interface uart_tx_arbiter_if #(
    parameter int DATA_BITS = 8
);
    logic                 a_valid;
    logic [DATA_BITS-1:0] a_data;
    logic                 a_ready;
    logic                 b_valid;
    logic [DATA_BITS-1:0] b_data;
    logic                 b_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shared 8N1 UART transmitter with round-robin arbitration between two byte requesters.
// It contains a per-bit baud counter and sends one frame at a time on a registered tx line.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst_l,
    uart_tx_arbiter_if.slave        req,
    output logic                    tx,
    output logic                    busy,
    output logic                    owner
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 last_grant;
    logic                 a_fire;
    logic                 b_fire;
    logic                 bit_end;

    // With both sides valid, the side that did not win last time is served.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        req.a_ready = 1'b0;
        req.b_ready = 1'b0;
        if (state == IDLE) begin
            if (req.a_valid && (!req.b_valid || last_grant))
                req.a_ready = 1'b1;
            else if (req.b_valid)
                req.b_ready = 1'b1;
        end
    end

    assign a_fire  = req.a_valid && req.a_ready;
    assign b_fire  = req.b_valid && req.b_ready;
    assign bit_end = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            owner      <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            // NOTE: the shift register is a plain register, not a memory, so it is reset with the rest.
            shift      <= '0;
            last_grant <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE: begin
                    if (a_fire || b_fire) begin
                        shift      <= a_fire ? req.a_data : req.b_data;
                        owner      <= b_fire;
                        last_grant <= b_fire;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        tx         <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Next data bit is shown on the same edge that shifts it into bit 0.
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench: one DUT at CLKS_PER_BIT=4 for the main scenarios and one at
// CLKS_PER_BIT=2 for the short-bit boundary.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_l = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_tx_arbiter_if #(.DATA_BITS(8)) if0 ();
    uart_tx_arbiter_if #(.DATA_BITS(8)) if1 ();
    logic tx0, busy0, owner0;
    logic tx1, busy1, owner1;

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut0 (
        .clk(clk), .rst_l(rst_l), .req(if0.slave), .tx(tx0), .busy(busy0), .owner(owner0)
    );
    uart_tx_arbiter #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut1 (
        .clk(clk), .rst_l(rst_l), .req(if1.slave), .tx(tx1), .busy(busy1), .owner(owner1)
    );

    always #5 clk = ~clk;

    // Expected tx for cycles 1..40 after a handshake (bit k-1 = cycle k), CLKS_PER_BIT=4.
    function automatic logic [39:0] expected_line(input logic [7:0] d);
        logic [39:0] r;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 4)       r[k-1] = 1'b0;
            else if (k <= 36) r[k-1] = d[(k-5)/4];
            else              r[k-1] = 1'b1;
        end
        return r;
    endfunction

    // Samples 40 cycles of DUT0 after a handshake; optionally rewrites a_data at cycle mod_cycle.
    task automatic observe_frame(input int mod_cycle, input logic [7:0] mod_data,
                                 output logic [39:0] line, output logic [39:0] bsy,
                                 output logic [39:0] rdy);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            line[k-1] = tx0;
            bsy[k-1]  = busy0;
            rdy[k-1]  = if0.a_ready | if0.b_ready;
            if (k == mod_cycle) if0.a_data = mod_data;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({tx0, busy0, if0.a_ready, if0.b_ready, owner0} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_dut0: got tx,busy,ar,br,owner=%b want 10000",
                     {tx0, busy0, if0.a_ready, if0.b_ready, owner0});
        end
        n_cmp++;
        if ({tx1, busy1, if1.a_ready, if1.b_ready, owner1} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_dut1: got tx,busy,ar,br,owner=%b want 10000",
                     {tx1, busy1, if1.a_ready, if1.b_ready, owner1});
        end
    endtask

    task automatic test_single_a();
        logic [39:0] line, bsy, rdy;
        if0.a_valid = 1'b1;
        if0.a_data  = 8'hA5;
        #1;
        n_cmp++;
        if ({if0.a_ready, if0.b_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_grant: got ar,br=%b want 10", {if0.a_ready, if0.b_ready});
        end
        observe_frame(0, 8'h00, line, bsy, rdy);
        n_cmp++;
        if (line !== expected_line(8'hA5)) begin
            n_bad++;
            $display("FAIL single_line: got %h want %h", line, expected_line(8'hA5));
        end
        n_cmp++;
        if (bsy !== {40{1'b1}}) begin
            n_bad++;
            $display("FAIL single_busy: got %h want ffffffffff", bsy);
        end
        n_cmp++;
        if (rdy !== 40'h0) begin
            n_bad++;
            $display("FAIL single_ready_in_frame: got %h want 0", rdy);
        end
        n_cmp++;
        if (owner0 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_owner: got %b want 0", owner0);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({if0.a_ready, busy0, tx0} !== 3'b101) begin
            n_bad++;
            $display("FAIL single_cycle41: got ar,busy,tx=%b want 101", {if0.a_ready, busy0, tx0});
        end
        if0.a_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic [39:0] line, bsy, rdy;
        logic [7:0]  d;
        logic        exp_b;
        if0.a_valid = 1'b1;
        if0.b_valid = 1'b1;
        if0.a_data  = 8'h11;
        if0.b_data  = 8'h22;
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        #1;
        for (int f = 0; f < 4; f++) begin
            exp_b = (f % 2 == 1);
            d = exp_b ? 8'h22 : 8'h11;
            n_cmp++;
            if ({if0.a_ready, if0.b_ready} !== (exp_b ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL contention_grant%0d: got ar,br=%b want %b", f,
                         {if0.a_ready, if0.b_ready}, exp_b ? 2'b01 : 2'b10);
            end
            observe_frame(0, 8'h00, line, bsy, rdy);
            n_cmp++;
            if (line !== expected_line(d) || bsy !== {40{1'b1}} || rdy !== 40'h0) begin
                n_bad++;
                $display("FAIL contention_frame%0d: got line=%h busy=%h rdy=%h want line=%h busy=ffffffffff rdy=0",
                         f, line, bsy, rdy, expected_line(d));
            end
            n_cmp++;
            if (owner0 !== exp_b) begin
                n_bad++;
                $display("FAIL contention_owner%0d: got %b want %b", f, owner0, exp_b);
            end
            if (f == 3) begin
                if0.a_valid = 1'b0;
                if0.b_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_data_hold();
        logic [39:0] line, bsy, rdy;
        if0.a_valid = 1'b1;
        if0.a_data  = 8'h55;
        #1;
        n_cmp++;
        if (if0.a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_grant: got ar=%b want 1", if0.a_ready);
        end
        observe_frame(2, 8'hFF, line, bsy, rdy);
        n_cmp++;
        if (line !== expected_line(8'h55)) begin
            n_bad++;
            $display("FAIL hold_line: got %h want %h", line, expected_line(8'h55));
        end
        n_cmp++;
        if (rdy !== 40'h0) begin
            n_bad++;
            $display("FAIL hold_ready_in_frame: got %h want 0", rdy);
        end
        if0.a_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic bad;
        if0.a_valid = 1'b1;
        if0.a_data  = 8'hF0;
        #1;
        n_cmp++;
        if (if0.a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_grant: got ar=%b want 1", if0.a_ready);
        end
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            @(negedge clk);
            if0.a_valid = 1'b0;
        end
        n_cmp++;
        if ({tx0, busy0} !== 2'b01) begin
            n_bad++;
            $display("FAIL midrst_bit3: got tx,busy=%b want 01", {tx0, busy0});
        end
        #2 rst_l = 1'b0;
        #1;
        n_cmp++;
        if ({tx0, busy0, owner0} !== 3'b100) begin
            n_bad++;
            $display("FAIL midrst_async: got tx,busy,owner=%b want 100", {tx0, busy0, owner0});
        end
        @(negedge clk);
        rst_l = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_residual: line left idle-high state after reset release");
        end
    endtask

    task automatic test_short_bit();
        logic [20:0] line, bsy;
        if1.a_valid = 1'b1;
        if1.a_data  = 8'h00;
        #1;
        n_cmp++;
        if (if1.a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL short_grant: got ar=%b want 1", if1.a_ready);
        end
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            @(negedge clk);
            line[k-1] = tx1;
            bsy[k-1]  = busy1;
            if (k == 1) if1.a_valid = 1'b0;
        end
        // Cycles 1-18 low, 19-20 high, 21 idle high.
        n_cmp++;
        if (line !== 21'b111_0000_0000_0000_0000_00) begin
            n_bad++;
            $display("FAIL short_line: got %b want 111000000000000000000", line);
        end
        n_cmp++;
        if (bsy !== 21'b011_1111_1111_1111_1111_11) begin
            n_bad++;
            $display("FAIL short_busy: got %b want 011111111111111111111", bsy);
        end
    endtask

    initial begin
        if0.a_valid = 1'b0; if0.b_valid = 1'b0; if0.a_data = '0; if0.b_data = '0;
        if1.a_valid = 1'b0; if1.b_valid = 1'b0; if1.a_data = '0; if1.b_data = '0;
        test_reset();
        test_single_a();
        test_contention();
        test_data_hold();
        test_mid_reset();
        test_short_bit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
